// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// MemPortArbiter (module mem_port_arbiter)
//
// Shares one synchronous single-port memory between NUM_CLIENTS requesters.
// Writes are posted (no response); reads go through a small FSM that issues
// the access, waits for the registered memory data and holds the response
// until the consumer takes it. At most one read is in flight at a time.
//
// Arbitration:
//   MEM_PORT_ARBITER_RR_EN defined   : round-robin. The search starts at a
//                                      pointer that moves to (winner + 1) mod
//                                      NUM_CLIENTS after every grant.
//   MEM_PORT_ARBITER_RR_EN undefined : fixed priority. The lowest eligible
//                                      index wins and there is no pointer.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_we         per-client request valid / write(1) or read(0)
//   req_addr/req_wdata       packed per-client address / write data
//   req_ready                one-hot grant, combinational
//   mem_we/mem_re            registered memory write / read enables
//   mem_addr/mem_wdata       registered memory address / write data
//   mem_rdata                registered read data from the memory
//   rsp_valid/rsp_ready      read response handshake
//   rsp_data/rsp_id          read data and the client it belongs to
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLIENTS-1:0]            req_valid,
   input  logic [NUM_CLIENTS-1:0]            req_we,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_CLIENTS-1:0]            req_ready,
   output logic                              mem_we,
   output logic                              mem_re,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [DATA_WIDTH-1:0]             rsp_data,
   output logic [$clog2(NUM_CLIENTS)-1:0]    rsp_id
);

   localparam int ID_W = $clog2(NUM_CLIENTS);

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RSP_HOLD
   } rdState_e;

   rdState_e              state_q;
   logic [ID_W-1:0]       pendId_q;
   logic                  rspValid_q;
   logic [DATA_WIDTH-1:0] rspData_q;
   logic [ID_W-1:0]       rspId_q;

   logic                  memWe_q;
   logic                  memRe_q;
   logic [ADDR_WIDTH-1:0] memAddr_q;
   logic [DATA_WIDTH-1:0] memWdata_q;

   logic                   readEligible;
   logic [NUM_CLIENTS-1:0] eligible;
   logic                   grantValid;
   logic [ID_W-1:0]        grantIdx;
   logic                   grantWe;
   logic [ADDR_WIDTH-1:0]  grantAddr;
   logic [DATA_WIDTH-1:0]  grantWdata;
   logic                   readAccept;

   // A read may only start when nothing is outstanding, or when the held
   // response leaves at this very edge, so the read path never overlaps.
   // Writes need no response and are always eligible.
   always_comb begin
      readEligible = (state_q == IDLE) || ((state_q == RSP_HOLD) && rsp_ready);
      eligible     = req_valid & (req_we | {NUM_CLIENTS{readEligible}});
   end

`ifdef MEM_PORT_ARBITER_RR_EN
   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;

   // Round-robin search starting at the pointer. The candidate index wraps
   // explicitly so that non-power-of-two client counts stay in range.
   // Ineligible reads are simply skipped, so they never block a write.
   always_comb begin
      logic [ID_W-1:0] cand;
      grantValid = 1'b0;
      grantIdx   = '0;
      ptr_d      = ptr_q;
      cand       = ptr_q;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (!grantValid && eligible[cand]) begin
            grantValid = 1'b1;
            grantIdx   = cand;
            ptr_d      = (cand == ID_W'(NUM_CLIENTS - 1)) ? '0 : cand + ID_W'(1);
         end
         cand = (cand == ID_W'(NUM_CLIENTS - 1)) ? '0 : cand + ID_W'(1);
      end
   end

   // The pointer only moves when somebody was actually granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (grantValid) begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: scanning from the top down leaves the lowest eligible
   // index as the final winner.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            grantValid = 1'b1;
            grantIdx   = ID_W'(k);
         end
      end
   end
`endif

   // Pick out the winner's request fields and build the one-hot ready.
   // Ready is forced low while reset is asserted.
   always_comb begin
      grantWe    = 1'b0;
      grantAddr  = '0;
      grantWdata = '0;
      req_ready  = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (grantIdx == ID_W'(k)) begin
            grantWe      = req_we[k];
            grantAddr    = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            grantWdata   = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            req_ready[k] = rst_n && grantValid;
         end
      end
      readAccept = grantValid && !grantWe;
   end

   // The accepted request drives the memory port for exactly one cycle.
   // Address and data hold their last value; only the enables matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memWe_q    <= 1'b0;
         memRe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         memWe_q <= grantValid && grantWe;
         memRe_q <= readAccept;
         if (grantValid) begin
            memAddr_q  <= grantAddr;
            memWdata_q <= grantWdata;
         end
      end
   end

   // Read FSM. RD_ISSUE is the cycle mem_re is on the port, RD_WAIT is the
   // cycle the memory's registered data becomes visible, and RSP_HOLD keeps
   // the captured response stable until the consumer accepts it. A new read
   // accepted on the handshake edge goes straight back to RD_ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pendId_q   <= '0;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         rspId_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (readAccept) begin
                  state_q  <= RD_ISSUE;
                  pendId_q <= grantIdx;
               end
            end
            RD_ISSUE: begin
               state_q <= RD_WAIT;
            end
            RD_WAIT: begin
               state_q    <= RSP_HOLD;
               rspValid_q <= 1'b1;
               rspData_q  <= mem_rdata;
               rspId_q    <= pendId_q;
            end
            RSP_HOLD: begin
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  if (readAccept) begin
                     state_q  <= RD_ISSUE;
                     pendId_q <= grantIdx;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_we    = memWe_q;
   assign mem_re    = memRe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign rsp_valid = rspValid_q;
   assign rsp_data  = rspData_q;
   assign rsp_id    = rspId_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of requesting clients, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data width of every client and of the memory port.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: address width of every client and of the memory port.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid, input, NUM_CLIENTS bits: per-client request valid.
REQ-007 SHALL have port req_we, input, NUM_CLIENTS bits: per-client write (1) or read (0).
REQ-008 SHALL have port req_addr, input, NUM_CLIENTS*ADDR_WIDTH bits: client i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port req_wdata, input, NUM_CLIENTS*DATA_WIDTH bits: client i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port req_ready, output, NUM_CLIENTS bits: one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-011 SHALL have ports mem_we and mem_re, output, 1 bit each: write and read enables for one memory port.
REQ-012 SHALL have ports mem_addr (ADDR_WIDTH) and mem_wdata (DATA_WIDTH), output: memory port address and write data.
REQ-013 SHALL have port mem_rdata, input, DATA_WIDTH bits: registered read data, valid the cycle after the memory samples mem_re.
REQ-014 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, DATA_WIDTH) and rsp_id (output, clog2(NUM_CLIENTS)): read response channel.

Function
REQ-015 SHALL grant at most one client per cycle; req_ready SHALL be combinational from req_valid, req_we and internal state.
REQ-016 SHALL treat a write as eligible every cycle and a read as eligible only in state IDLE, or in RSP_HOLD while rsp_ready=1.
REQ-017 SHALL register the granted request into mem_we, mem_re, mem_addr and mem_wdata for exactly one cycle after acceptance; otherwise mem_we=mem_re=0.
REQ-018 SHALL use the read FSM IDLE -> RD_ISSUE (read accepted) -> RD_WAIT (always) -> RSP_HOLD (mem_rdata captured into rsp_data, rsp_valid=1). RSP_HOLD SHALL go to IDLE on rsp_ready=1, or to RD_ISSUE if a new read is accepted at the same edge.
REQ-019 SHALL deliver read latency of 2 cycles: read accepted at edge k, so rsp_valid=1 after edge k+2.
REQ-020 SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL produce no response for writes. A write accepted at edge k and a read of the same address accepted at edge k+1 SHALL return the new data.
REQ-022 SHALL advance the arbitration pointer to (granted index + 1) mod NUM_CLIENTS after each grant, with pointer wrap-around.
REQ-023 SHALL skip ineligible reads during arbitration without blocking lower-priority eligible writes.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, pointer=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_id=0 and req_ready=0.
REQ-025 SHALL discard any in-flight read on reset assertion mid-operation, with no response emitted after deassertion.

Configuration
REQ-026 SHALL, when MEM_PORT_ARBITER_RR_EN is defined, arbitrate round-robin per REQ-022.
REQ-027 SHALL, when MEM_PORT_ARBITER_RR_EN is undefined, use fixed priority (lowest eligible index wins) and remove the pointer logic.

Verification
REQ-028 SHALL cover reset and write: client 2 writes addr 0x5 data 0xA5 -> mem_we=1, mem_addr=0x5, mem_wdata=0xA5 for one cycle.
REQ-029 SHALL cover read-after-write: client 0 writes 0x3/0x3C, then client 1 reads 0x3 -> rsp_valid 2 cycles after acceptance, rsp_data=0x3C, rsp_id=1.
REQ-030 SHALL cover round-robin: all 4 clients write continuously -> grants 0,1,2,3,0; with the macro undefined, client 0 is granted every cycle.
REQ-031 SHALL cover backpressure: rsp_ready=0 for 5 cycles with reads pending -> rsp_data held, no read granted, writes still granted.
REQ-032 SHALL cover back-to-back reads: rsp_ready=1 continuously with reads pending -> a new read is accepted on the response handshake edge and responses arrive every 3 cycles.
REQ-033 SHALL cover reset mid-read: rst_n=0 during RD_WAIT -> rsp_valid stays 0 and the FSM is IDLE after release.
